// File: rtl/rl_ram_pkg.sv
// Shared types and helpers for the rl_ram_1r1w_bypass block: sweep FSM states
// and the byte-lane merge used by the write port bypass.
package rl_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Widest data word the lane-merge helper handles; callers zero-extend.
  localparam int MERGE_W = 256;

  // Per-bit select between old and new data, driven by the lane enable that
  // owns each bit. Lane width is a run-time argument so a partial top lane works.
  function automatic logic [MERGE_W-1:0] merge_be(
    input logic [MERGE_W-1:0] old_data,
    input logic [MERGE_W-1:0] new_data,
    input logic [MERGE_W-1:0] be,
    input int                 bbits
  );
    logic [MERGE_W-1:0] merged;
    merged = old_data;
    for (int i = 0; i < MERGE_W; i++) begin
      if (be[i / bbits]) merged[i] = new_data[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/rl_ram_1r1w_array.sv
// Inferred storage for rl_ram_1r1w_bypass: one registered read port, one
// byte-enabled write port.
module rl_ram_1r1w_array #(
  parameter int ABITS     = 10,
  parameter int DBITS     = 32,
  parameter int BBITS     = 8,
  parameter int NBE       = (DBITS + BBITS - 1) / BBITS,
  parameter     INIT_FILE = ""
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [DBITS-1:0] din_i,
  input  logic [NBE-1:0]   be_i,
  input  logic             re_i,
  input  logic [ABITS-1:0] raddr_i,
  output logic [DBITS-1:0] dout_o
);

  logic [DBITS-1:0] mem [2**ABITS];

  // NOTE: the array has no reset; clearing it is the job of the sweep FSM in
  // the top, which keeps the storage mappable onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DBITS; b++) begin
        if (be_i[b / BBITS]) mem[waddr_i][b] <= din_i[b];
      end
    end
  end

  // Read-before-write: a same-address write lands after this sample.
  always_ff @(posedge clk_i) begin
    if (re_i) dout_o <= mem[raddr_i];
  end

endmodule

// File: rtl/rl_ram_1r1w_bypass.sv
// 1R1W RAM with write-first collision bypass and 1- or 2-cycle read latency.
// Define RL_RAM_1R1W_CLEAR_EN to zero the whole array after every reset.
module rl_ram_1r1w_bypass
  import rl_ram_pkg::*;
#(
  parameter int ABITS      = 10,
  parameter int DBITS      = 32,
  parameter int BBITS      = 8,
  parameter int RD_LATENCY = 1,
  parameter     INIT_FILE  = "",
  localparam int NBE       = (DBITS + BBITS - 1) / BBITS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [DBITS-1:0] din_i,
  input  logic             we_i,
  input  logic [NBE-1:0]   be_i,
  input  logic [ABITS-1:0] raddr_i,
  input  logic             re_i,
  output logic [DBITS-1:0] dout_o,
  output logic             dvalid_o,
  output logic             busy_o
);

  function automatic logic [DBITS-1:0] lane_merge(
    input logic [DBITS-1:0] old_d,
    input logic [DBITS-1:0] new_d,
    input logic [NBE-1:0]   be
  );
    logic [MERGE_W-1:0] wo, wn, wb, wr;
    wo = '0;
    wn = '0;
    wb = '0;
    wo[DBITS-1:0] = old_d;
    wn[DBITS-1:0] = new_d;
    wb[NBE-1:0]   = be;
    wr = merge_be(wo, wn, wb, BBITS);
    return wr[DBITS-1:0];
  endfunction

  logic             busy;
  logic             wr_req, rd_acc;
  logic             arr_we;
  logic [ABITS-1:0] arr_waddr;
  logic [DBITS-1:0] arr_din;
  logic [NBE-1:0]   arr_be;
  logic [DBITS-1:0] rd_data;

  assign wr_req = we_i & (|be_i) & ~busy & ~rst_i;
  assign rd_acc = re_i & ~busy & ~rst_i;

`ifdef RL_RAM_1R1W_CLEAR_EN
  state_e           state;
  logic [ABITS-1:0] clr_addr;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == '1) state <= READY;
    end
  end

  assign busy = (state == CLEAR);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and a latch cannot be inferred.
  always_comb begin
    arr_we    = wr_req;
    arr_waddr = waddr_i;
    arr_din   = din_i;
    arr_be    = be_i;
    if (busy && !rst_i) begin
      arr_we    = 1'b1;
      arr_waddr = clr_addr;
      arr_din   = '0;
      arr_be    = '1;
    end
  end
`else
  assign busy      = 1'b0;
  assign arr_we    = wr_req;
  assign arr_waddr = waddr_i;
  assign arr_din   = din_i;
  assign arr_be    = be_i;
`endif

  rl_ram_1r1w_array #(
    .ABITS    (ABITS),
    .DBITS    (DBITS),
    .BBITS    (BBITS),
    .NBE      (NBE),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (arr_we),
    .waddr_i(arr_waddr),
    .din_i  (arr_din),
    .be_i   (arr_be),
    .re_i   (rd_acc),
    .raddr_i(raddr_i),
    .dout_o (rd_data)
  );

  // Stage 1: the array returns pre-write data, so patch in a colliding write.
  logic             s1_valid, s1_hit;
  logic [DBITS-1:0] s1_din, s1_data;
  logic [NBE-1:0]   s1_be;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
    end else begin
      s1_valid <= rd_acc;
      s1_hit   <= rd_acc & wr_req & (raddr_i == waddr_i);
    end
  end

  always_ff @(posedge clk_i) begin
    s1_din <= din_i;
    s1_be  <= be_i;
  end

  assign s1_data = s1_hit ? lane_merge(rd_data, s1_din, s1_be) : rd_data;

  logic             out_valid;
  logic [DBITS-1:0] out_data;

  if (RD_LATENCY == 1) begin : g_lat1
    assign out_valid = s1_valid;
    assign out_data  = s1_data;
  end else begin : g_lat2
    logic [ABITS-1:0] s1_addr;
    logic             s2_valid;
    logic [DBITS-1:0] s2_data;

    always_ff @(posedge clk_i) begin
      if (rst_i) s2_valid <= 1'b0;
      else       s2_valid <= s1_valid;
    end

    // A write one cycle behind the read is folded in as well.
    always_ff @(posedge clk_i) begin
      s1_addr <= raddr_i;
      s2_data <= (s1_valid && wr_req && (waddr_i == s1_addr))
                 ? lane_merge(s1_data, din_i, be_i) : s1_data;
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
  end

  logic [DBITS-1:0] dout_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)          dout_q <= '0;
    else if (out_valid) dout_q <= out_data;
  end

  assign dvalid_o = out_valid & ~rst_i;
  assign dout_o   = rst_i ? '0 : (out_valid ? out_data : dout_q);
  assign busy_o   = busy;

endmodule

// File: tb/tb_rl_ram_1r1w_bypass.sv
// Bench for rl_ram_1r1w_bypass: latency-1 and latency-2 instances on shared
// stimulus, directed vector table plus random traffic against a reference model.
module tb_rl_ram_1r1w_bypass;

  localparam int ABITS = 4;
  localparam int DBITS = 32;
  localparam int BBITS = 8;
  localparam int NBE   = 4;
  localparam int DEPTH = 16;
`ifdef RL_RAM_1R1W_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_i, we_i, re_i;
  logic [ABITS-1:0] waddr_i, raddr_i;
  logic [DBITS-1:0] din_i;
  logic [NBE-1:0]   be_i;
  logic [DBITS-1:0] dout1, dout2;
  logic             dvalid1, dvalid2, busy1, busy2;

  always #5 clk = ~clk;

  rl_ram_1r1w_bypass #(.ABITS(ABITS), .DBITS(DBITS), .BBITS(BBITS),
                       .RD_LATENCY(1), .INIT_FILE("")) u_l1 (
    .clk_i(clk), .rst_i(rst_i), .waddr_i(waddr_i), .din_i(din_i), .we_i(we_i),
    .be_i(be_i), .raddr_i(raddr_i), .re_i(re_i), .dout_o(dout1),
    .dvalid_o(dvalid1), .busy_o(busy1));

  rl_ram_1r1w_bypass #(.ABITS(ABITS), .DBITS(DBITS), .BBITS(BBITS),
                       .RD_LATENCY(2), .INIT_FILE("")) u_l2 (
    .clk_i(clk), .rst_i(rst_i), .waddr_i(waddr_i), .din_i(din_i), .we_i(we_i),
    .be_i(be_i), .raddr_i(raddr_i), .re_i(re_i), .dout_o(dout2),
    .dvalid_o(dvalid2), .busy_o(busy2));

  typedef struct {
    logic             rst, we, re;
    logic [NBE-1:0]   be;
    logic [ABITS-1:0] waddr, raddr;
    logic [DBITS-1:0] din;
    bit               chk;
    logic             ev1, ev2;
    logic [DBITS-1:0] ed1, ed2;
  } vec_t;

  typedef struct {
    int               lat;
    int               addr;
    int               last;
    int               out;
    logic [DBITS-1:0] data;
  } rd_t;

  // Reference model: plain memory plus queues of outstanding reads.
  logic [DBITS-1:0] mem_m [DEPTH];
  rd_t              pend_q[$];
  rd_t              out_q[$];
  logic [DBITS-1:0] held1, held2;
  int               busy_cnt;
  int               cyc;
  int               tests, fails;
  int               vcount1, vcount2, busy_seen;

  task automatic check(input string name, input logic [DBITS-1:0] act,
                       input logic [DBITS-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic we,
                              input logic [ABITS-1:0] wa, input logic [DBITS-1:0] d,
                              input logic [NBE-1:0] be, input logic re,
                              input logic [ABITS-1:0] ra, input bit chk,
                              input logic ev1, input logic [DBITS-1:0] ed1,
                              input logic ev2, input logic [DBITS-1:0] ed2);
    vec_t v;
    v.rst = rst; v.we = we; v.waddr = wa; v.din = d; v.be = be; v.re = re;
    v.raddr = ra; v.chk = chk; v.ev1 = ev1; v.ed1 = ed1; v.ev2 = ev2; v.ed2 = ed2;
    return v;
  endfunction

  task automatic model_check();
    logic             ev [1:2];
    logic [DBITS-1:0] ed [1:2];
    for (int l = 1; l <= 2; l++) begin
      ev[l] = 1'b0;
      ed[l] = (l == 1) ? held1 : held2;
      for (int i = out_q.size() - 1; i >= 0; i--) begin
        if (out_q[i].lat == l && out_q[i].out == cyc) begin
          ev[l] = 1'b1;
          ed[l] = out_q[i].data;
          out_q.delete(i);
        end
      end
      if (rst_i) begin
        ev[l] = 1'b0;
        ed[l] = '0;
      end else if (ev[l]) begin
        if (l == 1) held1 = ed[l];
        else        held2 = ed[l];
      end
    end
    check("l1_dvalid", {31'b0, dvalid1}, {31'b0, ev[1]});
    check("l1_dout",   dout1, ed[1]);
    check("l2_dvalid", {31'b0, dvalid2}, {31'b0, ev[2]});
    check("l2_dout",   dout2, ed[2]);
    if (!rst_i) begin
      check("l1_busy", {31'b0, busy1}, {31'b0, CLEAR_EN && busy_cnt > 0});
      check("l2_busy", {31'b0, busy2}, {31'b0, CLEAR_EN && busy_cnt > 0});
      if (busy1 === 1'b1) busy_seen++;
    end
    if (dvalid1 === 1'b1) vcount1++;
    if (dvalid2 === 1'b1) vcount2++;
  endtask

  task automatic model_edge();
    if (rst_i) begin
      pend_q.delete();
      out_q.delete();
      held1 = '0;
      held2 = '0;
      if (CLEAR_EN) begin
        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
        busy_cnt = DEPTH;
      end
    end else if (CLEAR_EN && busy_cnt > 0) begin
      busy_cnt--;
    end else begin
      if (we_i) begin
        for (int k = 0; k < NBE; k++)
          if (be_i[k]) mem_m[int'(waddr_i)][k*BBITS +: BBITS] = din_i[k*BBITS +: BBITS];
      end
      if (re_i) begin
        for (int l = 1; l <= 2; l++) begin
          rd_t r;
          r.lat = l; r.addr = int'(raddr_i); r.last = cyc + l - 1;
          r.out = cyc + l; r.data = '0;
          pend_q.push_back(r);
        end
      end
    end
    // A read's data is the memory image after every write up to its last cycle.
    for (int i = pend_q.size() - 1; i >= 0; i--) begin
      if (pend_q[i].last == cyc) begin
        rd_t r;
        r = pend_q[i];
        r.data = mem_m[r.addr];
        out_q.push_back(r);
        pend_q.delete(i);
      end
    end
    cyc++;
  endtask

  task automatic run(input vec_t v);
    rst_i = v.rst; we_i = v.we; waddr_i = v.waddr; din_i = v.din;
    be_i = v.be; re_i = v.re; raddr_i = v.raddr;
    @(negedge clk);
    model_check();
    if (v.chk) begin
      check("tbl_l1_dvalid", {31'b0, dvalid1}, {31'b0, v.ev1});
      check("tbl_l1_dout",   dout1, v.ed1);
      check("tbl_l2_dvalid", {31'b0, dvalid2}, {31'b0, v.ev2});
      check("tbl_l2_dout",   dout2, v.ed2);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic wr(input int a, input logic [DBITS-1:0] d);
    run(mk(0, 1, ABITS'(a), d, 4'hF, 0, 0, 0, 0, 0, 0, 0));
  endtask

  vec_t tbl [12];
  int   v0, b0;

  initial begin
    tests = 0; fails = 0; cyc = 0; busy_cnt = 0;
    vcount1 = 0; vcount2 = 0; busy_seen = 0;
    held1 = '0; held2 = '0;
    for (int a = 0; a < DEPTH; a++) mem_m[a] = 'x;
    rst_i = 1'b1; we_i = 1'b0; re_i = 1'b0; waddr_i = '0; raddr_i = '0;
    din_i = '0; be_i = '0;
    @(posedge clk);
    #1;

    // Reset and let any sweep finish, then give every address a known value.
    run(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    run(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    idle(DEPTH + 2);
    for (int a = 0; a < DEPTH; a++) wr(a, 32'h1000_0000 + 32'(a));

    //            rst we wa   din            be    re ra  chk ev1 ed1            ev2 ed2
    tbl[0]  = mk(0, 1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 1, 0, 32'h0,         0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,        4'h0, 1, 5, 1, 0, 32'h0,         0, 32'h0);
    tbl[2]  = mk(0, 1, 3, 32'h11223344, 4'hF, 0, 0, 1, 1, 32'hDEADBEEF,  0, 32'h0);
    tbl[3]  = mk(0, 1, 3, 32'hAABBCCDD, 4'h5, 1, 3, 1, 0, 32'hDEADBEEF,  1, 32'hDEADBEEF);
    tbl[4]  = mk(0, 1, 7, 32'h0,        4'hF, 0, 0, 1, 1, 32'h11BB33DD,  0, 32'hDEADBEEF);
    tbl[5]  = mk(0, 0, 0, 32'h0,        4'h0, 1, 7, 1, 0, 32'h11BB33DD,  1, 32'h11BB33DD);
    tbl[6]  = mk(0, 1, 7, 32'h55,       4'h1, 0, 0, 1, 1, 32'h0,         0, 32'h11BB33DD);
    tbl[7]  = mk(0, 1, 9, 32'hFFFFFFFF, 4'h0, 0, 0, 1, 0, 32'h0,         1, 32'h00000055);
    tbl[8]  = mk(0, 0, 0, 32'h0,        4'h0, 1, 5, 1, 0, 32'h0,         0, 32'h00000055);
    tbl[9]  = mk(1, 0, 0, 32'h0,        4'h0, 0, 0, 1, 0, 32'h0,         0, 32'h0);
    tbl[10] = mk(0, 0, 0, 32'h0,        4'h0, 0, 0, 1, 0, 32'h0,         0, 32'h0);
    tbl[11] = mk(0, 0, 0, 32'h0,        4'h0, 1, 9, 0, 0, 32'h0,         0, 32'h0);
    for (int i = 0; i < 12; i++) run(tbl[i]);
    idle(DEPTH + 2);

    // Sixteen back-to-back reads must give sixteen consecutive pulses.
    for (int a = 0; a < DEPTH; a++) wr(a, 32'hA500_0000 ^ (32'(a) * 32'h0101_0101));
    v0 = vcount1;
    b0 = vcount2;
    for (int a = 0; a < DEPTH; a++)
      run(mk(0, 0, 0, 0, 0, 1, ABITS'(a), 0, 0, 0, 0, 0));
    idle(3);
    check("tput_l1_pulses", 32'(vcount1 - v0), 32'd16);
    check("tput_l2_pulses", 32'(vcount2 - b0), 32'd16);

    // Fill with ones, reset, count busy cycles, then read everything back.
    for (int a = 0; a < DEPTH; a++) wr(a, 32'hFFFF_FFFF);
    run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    b0 = busy_seen;
    for (int i = 0; i < DEPTH + 4; i++)
      run(mk(0, 1, ABITS'(i), 32'h1234_5678, 4'hF, 1, ABITS'(i), 0, 0, 0, 0, 0));
    check("clear_busy_cycles", 32'(busy_seen - b0), CLEAR_EN ? 32'd16 : 32'd0);
    for (int a = 0; a < DEPTH; a++)
      run(mk(0, 0, 0, 0, 0, 1, ABITS'(a), 0, 0, 0, 0, 0));
    idle(3);

    // Random traffic with a narrow address range to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      v = mk($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
             ABITS'($urandom_range(0, 3)), $urandom(), NBE'($urandom_range(0, 15)),
             $urandom_range(0, 1) == 1, ABITS'($urandom_range(0, 3)), 0, 0, 0, 0, 0);
      run(v);
    end
    idle(DEPTH + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
